// File: rtl/mask_builder_pkg.sv
// Shared encodings and constants for mask_builder.
// MASK_BUILDER_FAST_EN selects four result bits per RUN cycle instead of one.
package mask_builder_pkg;

    localparam int WIDTH     = 32;
    localparam int LEN_LIMIT = 32;

`ifdef MASK_BUILDER_FAST_EN
    localparam int LANES = 4;
`else
    localparam int LANES = 1;
`endif

    typedef enum logic [1:0] {
        OP_MASK    = 2'b00,
        OP_FRONT   = 2'b01,
        OP_BACK    = 2'b10,
        OP_DEPOSIT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic [5:0] clamp_len(input logic [5:0] raw_len);
        return (raw_len > 6'(LEN_LIMIT)) ? 6'(LEN_LIMIT) : raw_len;
    endfunction

endpackage

// File: rtl/mask_builder_bit_slice.sv
// Combinational generator for one result bit of mask_builder, given the
// latched operands and the bit index being written.
module mask_bit_slice
    import mask_builder_pkg::*;
(
    input  op_e                op,
    input  logic [4:0]         pos,
    input  logic [5:0]         eff_len,
    input  logic [WIDTH-1:0]   src,
    input  logic [4:0]         idx,
    output logic               value
);

    logic [6:0] field_end;
    logic       in_field;
    logic [4:0] src_idx;

    // Field end is formed at 7 bits so pos+L never wraps back into range.
    assign field_end = {2'b00, pos} + {1'b0, eff_len};
    assign in_field  = (idx >= pos) && ({2'b00, idx} < field_end);
    assign src_idx   = idx - pos;

    always_comb begin
        // NOTE: default first so every path assigns value and no latch is inferred.
        value = 1'b0;
        case (op)
            OP_MASK:    value = in_field;
            OP_FRONT:   value = ({2'b00, idx} + {1'b0, eff_len}) >= 7'(WIDTH);
            OP_BACK:    value = {1'b0, idx} < eff_len;
            OP_DEPOSIT: value = in_field & src[src_idx];
            default:    value = 1'b0;
        endcase
    end

endmodule

// File: rtl/mask_builder.sv
// Start/busy/done mask and deposit generator writing LANES result bits per cycle.
// Build with MASK_BUILDER_FAST_EN defined for the four-bit-per-cycle variant.
module mask_builder
    import mask_builder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [4:0]         pos,
    input  logic [5:0]         len,
    input  logic [WIDTH-1:0]   src,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_e             state, state_d;
    logic [4:0]         bit_idx;
    op_e                op_q;
    logic [4:0]         pos_q;
    logic [5:0]         len_q;
    logic [WIDTH-1:0]   src_q;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               last_step;
    logic [4:0]         lane_idx [LANES];
    logic [LANES-1:0]   lane_bit;

    assign last_step = (bit_idx == 5'(WIDTH - LANES));
    assign result    = result_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_idx[k] = bit_idx + 5'(k);
        mask_bit_slice u_slice (
            .op      (op_q),
            .pos     (pos_q),
            .eff_len (len_q),
            .src     (src_q),
            .idx     (lane_idx[k]),
            .value   (lane_bit[k])
        );
    end

    always_comb begin
        result_d = result_q;
        for (int k = 0; k < LANES; k++) result_d[lane_idx[k]] = lane_bit[k];
    end

    always_ff @(posedge clk) begin
        // NOTE: the result register is reset along with the control state, since it is visible on the port.
        if (reset) begin
            bit_idx  <= '0;
            op_q     <= OP_MASK;
            pos_q    <= '0;
            len_q    <= '0;
            src_q    <= '0;
            result_q <= '0;
        end else if (state == IDLE && start) begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            bit_idx  <= '0;
            op_q     <= op_e'(op);
            pos_q    <= pos;
            len_q    <= clamp_len(len);
            src_q    <= src;
            result_q <= '0;
        end else if (state == RUN) begin
            result_q <= result_d;
            bit_idx  <= bit_idx + 5'(LANES);
        end
    end

endmodule

// File: tb/tb_mask_builder.sv
// Directed self-checking bench for mask_builder (both default and
// MASK_BUILDER_FAST_EN builds).
module tb_mask_builder;

`ifdef MASK_BUILDER_FAST_EN
    localparam int LAT     = 8;
    localparam int RST_CYC = 4;
`else
    localparam int LAT     = 32;
    localparam int RST_CYC = 10;
`endif

    localparam logic [1:0] MASK = 2'b00, FRONT = 2'b01, BACK = 2'b10, DEPOSIT = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [4:0]  pos = '0;
    logic [5:0]  len = '0;
    logic [31:0] src = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mask_builder dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .pos    (pos),
        .len    (len),
        .src    (src),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // inj_kind: 0 none, 1 second start (FRONT len=32) at busy cycle inj_cycle, 2 reset at inj_cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [4:0] p,
                          input logic [5:0] l, input logic [31:0] s, input logic [31:0] exp_result,
                          input int inj_cycle, input int inj_kind);
        int busy_cnt, done_at, done_cnt;
        busy_cnt = 0;
        done_at  = 0;
        done_cnt = 0;
        @(negedge clk);
        op = o; pos = p; len = l; src = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = '0; pos = '0; len = '0; src = '0;
        for (int n = 1; n <= LAT + 4; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (inj_kind != 0 && n == inj_cycle) begin
                if (inj_kind == 1) begin
                    start = 1'b1; op = FRONT; pos = 5'd0; len = 6'd32; src = '1;
                end else begin
                    reset = 1'b1;
                end
                @(posedge clk);
                #1;
                start = 1'b0; reset = 1'b0;
                if (inj_kind == 2) begin
                    check({tag, " busy after reset"}, 32'(busy), 32'd0);
                    check({tag, " result after reset"}, result, 32'd0);
                    check({tag, " done after reset"}, 32'(done), 32'd0);
                end
            end
        end
        if (inj_kind == 2) begin
            check({tag, " no done pulse"}, 32'(done_cnt), 32'd0);
            check({tag, " busy cycles"}, 32'(busy_cnt), 32'(inj_cycle));
        end else begin
            check({tag, " result"}, result, exp_result);
            check({tag, " done latency"}, 32'(done_at), 32'(LAT + 1));
            check({tag, " busy cycles"}, 32'(busy_cnt), 32'(LAT));
            check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;

        run_op("mask p4 l8",      MASK,    5'd4,  6'd8,  32'h0, 32'h0000_0FF0, 0, 0);
        run_op("front l3",        FRONT,   5'd0,  6'd3,  32'h0, 32'hE000_0000, 0, 0);
        run_op("back l40",        BACK,    5'd0,  6'd40, 32'h0, 32'hFFFF_FFFF, 0, 0);
        run_op("mask l0",         MASK,    5'd9,  6'd0,  32'h0, 32'h0000_0000, 0, 0);
        run_op("deposit p28 l16", DEPOSIT, 5'd28, 6'd16, 32'h0000_ABCD, 32'hD000_0000, 0, 0);
        run_op("deposit p8 l8",   DEPOSIT, 5'd8,  6'd8,  32'h1234_5678, 32'h0000_7800, 0, 0);
        run_op("mask p30 l8",     MASK,    5'd30, 6'd8,  32'h0, 32'hC000_0000, 0, 0);
        run_op("mask p31 l63",    MASK,    5'd31, 6'd63, 32'h0, 32'h8000_0000, 0, 0);
        run_op("deposit p0 l63",  DEPOSIT, 5'd0,  6'd63, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
        run_op("ignored start",   MASK,    5'd0,  6'd1,  32'h0, 32'h0000_0001, 5, 1);
        run_op("reset abort",     MASK,    5'd0,  6'd20, 32'h0, 32'h0000_0000, RST_CYC, 2);
        run_op("back l5",         BACK,    5'd0,  6'd5,  32'h0, 32'h0000_001F, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
